wb_rr_arbiter: RTL and testbench
================================

Name: wb_rr_arbiter

Overview:
Round-robin Wishbone (pipelined, with stall) arbiter that shares one slave port between NUM_M bus masters. It sits in front of a shared resource such as the RAM or peripheral crossbar port, where a DMA or debug master must coexist with the CPU cluster. It locks the grant for the whole cyc_o period of the winning master and tracks outstanding requests. A watchdog aborts a bus cycle whose slave stops acknowledging.

Parameters:
NUM_M, 2, number of masters (2..4)
AW, 32, address width
DW, 32, data width (sel width = DW/8)
MAX_OUTST, 4, maximum un-acked requests in flight (1..15)
TIMEOUT, 256, cycles without ack/err while outstanding>0 before abort; 0 disables the watchdog

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous reset, active-high
m_adr_i  in  NUM_M*AW  master addresses, master k at [k*AW +: AW]
m_dat_i  in  NUM_M*DW  master write data, packed the same way
m_sel_i  in  NUM_M*DW/8  master byte selects
m_we_i  in  NUM_M  master write enables
m_cyc_i  in  NUM_M  master cycle, used as the request
m_stb_i  in  NUM_M  master strobes
m_dat_o  out  DW  read data broadcast to all masters (= s_dat_i)
m_ack_o  out  NUM_M  per-master ack
m_err_o  out  NUM_M  per-master err
m_stall_o  out  NUM_M  per-master stall
s_adr_o  out  AW  slave address
s_dat_o  out  DW  slave write data
s_sel_o  out  DW/8  slave byte select
s_we_o  out  1  slave write enable
s_cyc_o  out  1  slave cycle
s_stb_o  out  1  slave strobe
s_dat_i  in  DW  slave read data
s_ack_i  in  1  slave ack
s_err_i  in  1  slave err
s_stall_i  in  1  slave stall
grant_o  out  NUM_M  one-hot current grant, 0 when idle (status)

Behaviour:
- States: IDLE, BUSY, ABORT. Reset sets IDLE, grant=0, last=NUM_M-1, outst=0, wdog=0.
- Reset values of outputs: s_cyc_o=0, s_stb_o=0, m_ack_o=0, m_err_o=0, m_stall_o=all 1, grant_o=0.
- Output mux and data are combinational. s_adr/dat/sel/we are driven from the granted master, or master 0 when idle.
- IDLE:
  - All m_stall_o=1 and s_cyc_o=0.
  - If any m_cyc_i is high, pick the first requester scanning from (last+1) mod NUM_M upward with wrap.
  - Register grant; next state BUSY. The grant takes effect 1 cycle after the request is seen.
- BUSY, with g = granted master:
  - s_cyc_o=m_cyc_i[g].
  - s_stb_o=m_stb_i[g] & (outst<MAX_OUTST).
  - m_stall_o[g]=s_stall_i | (outst==MAX_OUTST); every other master's stall=1.
  - m_ack_o[g]=s_ack_i and m_err_o[g]=s_err_i, gated by outst>0. An ack/err arriving with outst==0 is dropped and not forwarded.
- Outstanding counter:
  - Issue = s_stb_o & ~s_stall_i; retire = (s_ack_i|s_err_i) & outst>0.
  - Issue and retire in the same cycle leave the count unchanged.
- Release: when m_cyc_i[g]==0 in BUSY, s_cyc_o drops in the same cycle. On the next edge: last=g, grant=0, outst=0, state IDLE. There is one dead cycle between owners.
- Watchdog:
  - wdog clears on any retire and while outst==0; otherwise it increments.
  - When TIMEOUT!=0 and wdog==TIMEOUT-1 with outst>0, go to ABORT.
- ABORT:
  - s_cyc_o=0 and s_stb_o=0.
  - m_err_o[g]=1 for exactly the first ABORT cycle; outst is cleared.
  - Stay until m_cyc_i[g]==0, then move to IDLE with last=g.
- Slave ack/err while in ABORT or IDLE is ignored.
- Reset asserted mid-transaction returns to reset values on the next edge; no ack/err is generated.
- A master that raises cyc while another holds the grant waits with stall=1 and receives no ack.

Test Plan:
- Single master 0: cyc+stb to adr 0x100, slave acks 2 cycles later -> s_cyc_o rises 1 cycle after m_cyc_i[0]; m_ack_o=2'b01; grant_o=01; returns to IDLE after cyc drops.
- Both masters request continuously after reset, each doing one transfer then dropping cyc -> grant sequence 01,10,01,10 with exactly 1 idle cycle between grants.
- Master 1 issues 6 back-to-back stb, slave stall=0, acks delayed 5 cycles, MAX_OUTST=4 -> m_stall_o[1]=1 once outst=4; never more than 4 un-acked; all 6 acks delivered to master 1 only.
- Issue and ack in the same cycle with outst=2 -> outst stays 2; s_stall_i=1 -> s_stb_o held, outst not incremented.
- TIMEOUT=8, slave never acks after 1 issue -> 8 cycles later s_cyc_o=0 and m_err_o[g] high for 1 cycle; when master drops cyc, the next requester is granted.
- Spurious s_ack_i with outst=0 -> no m_ack_o. Reset asserted mid-burst -> all outputs return to reset values next cycle.

Source files
------------

// File: rtl/wb_rr_arbiter.sv
// Round-robin arbiter sharing one pipelined Wishbone slave port between NUM_M masters.
// The grant is held for the owner's whole cyc period; a watchdog aborts a slave that stops acking.
//
// state | meaning
// IDLE  | no owner, all masters stalled, choosing the next requester
// BUSY  | granted master drives the slave port, outstanding requests tracked
// ABORT | watchdog fired, err returned once, waiting for the owner to drop cyc
module wb_rr_arbiter #(
    parameter int NUM_M     = 2,
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int MAX_OUTST = 4,
    parameter int TIMEOUT   = 256
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [NUM_M*AW-1:0]     m_adr_i,
    input  logic [NUM_M*DW-1:0]     m_dat_i,
    input  logic [NUM_M*DW/8-1:0]   m_sel_i,
    input  logic [NUM_M-1:0]        m_we_i,
    input  logic [NUM_M-1:0]        m_cyc_i,
    input  logic [NUM_M-1:0]        m_stb_i,
    output logic [DW-1:0]           m_dat_o,
    output logic [NUM_M-1:0]        m_ack_o,
    output logic [NUM_M-1:0]        m_err_o,
    output logic [NUM_M-1:0]        m_stall_o,
    output logic [AW-1:0]           s_adr_o,
    output logic [DW-1:0]           s_dat_o,
    output logic [DW/8-1:0]         s_sel_o,
    output logic                    s_we_o,
    output logic                    s_cyc_o,
    output logic                    s_stb_o,
    input  logic [DW-1:0]           s_dat_i,
    input  logic                    s_ack_i,
    input  logic                    s_err_i,
    input  logic                    s_stall_i,
    output logic [NUM_M-1:0]        grant_o
);

    localparam int SW = DW / 8;
    localparam int IW = (NUM_M > 1) ? $clog2(NUM_M) : 1;
    localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, ABORT} state_t;

    state_t           state_q, state_d;
    logic [IW-1:0]    gidx_q, gidx_d;
    logic [IW-1:0]    last_q, last_d;
    logic [NUM_M-1:0] grant_q, grant_d;
    logic [3:0]       outst_q, outst_d;
    logic [WW-1:0]    wdog_q, wdog_d;
    logic             first_q, first_d;

    logic [IW-1:0]    sel;
    logic [IW-1:0]    scan;
    logic [IW-1:0]    pick;
    logic             found;
    logic             have_outst;
    logic             full;
    logic             issue;
    logic             retire;

    assign sel        = (state_q == IDLE) ? '0 : gidx_q;
    assign s_adr_o    = m_adr_i[sel*AW +: AW];
    assign s_dat_o    = m_dat_i[sel*DW +: DW];
    assign s_sel_o    = m_sel_i[sel*SW +: SW];
    assign s_we_o     = m_we_i[sel];
    assign m_dat_o    = s_dat_i;
    assign grant_o    = grant_q;
    assign have_outst = (outst_q != 4'd0);
    assign full       = (outst_q == 4'(MAX_OUTST));

    // Scan starts one past the last owner and wraps, so the last owner is checked last.
    always_comb begin
        scan  = last_q;
        pick  = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_M; i++) begin
            scan = (scan == IW'(NUM_M - 1)) ? '0 : scan + IW'(1);
            if (!found && m_cyc_i[scan]) begin
                pick  = scan;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        gidx_d    = gidx_q;
        last_d    = last_q;
        grant_d   = grant_q;
        outst_d   = outst_q;
        wdog_d    = wdog_q;
        first_d   = 1'b0;
        s_cyc_o   = 1'b0;
        s_stb_o   = 1'b0;
        m_ack_o   = '0;
        m_err_o   = '0;
        m_stall_o = '1;
        issue     = 1'b0;
        retire    = 1'b0;

        case (state_q)
            IDLE: begin
                outst_d = '0;
                wdog_d  = '0;
                if (found) begin
                    gidx_d  = pick;
                    grant_d = NUM_M'(1) << pick;
                    state_d = BUSY;
                end
            end

            BUSY: begin
                s_cyc_o           = m_cyc_i[gidx_q];
                s_stb_o           = m_cyc_i[gidx_q] & m_stb_i[gidx_q] & ~full;
                m_stall_o[gidx_q] = s_stall_i | full;
                m_ack_o[gidx_q]   = s_ack_i & have_outst;
                m_err_o[gidx_q]   = s_err_i & have_outst;
                issue             = s_stb_o & ~s_stall_i;
                retire            = (s_ack_i | s_err_i) & have_outst;

                if (issue && !retire)
                    outst_d = outst_q + 4'd1;
                else if (retire && !issue)
                    outst_d = outst_q - 4'd1;

                wdog_d = (retire || !have_outst) ? '0 : wdog_q + WW'(1);

                if (!m_cyc_i[gidx_q]) begin
                    state_d = IDLE;
                    last_d  = gidx_q;
                    grant_d = '0;
                    outst_d = '0;
                    wdog_d  = '0;
                end else if (TIMEOUT != 0 && have_outst && !retire &&
                             wdog_q == WW'(TIMEOUT - 1)) begin
                    state_d = ABORT;
                    first_d = 1'b1;
                    outst_d = '0;
                    wdog_d  = '0;
                end
            end

            ABORT: begin
                m_err_o[gidx_q] = first_q;
                outst_d         = '0;
                wdog_d          = '0;
                if (!m_cyc_i[gidx_q]) begin
                    state_d = IDLE;
                    last_d  = gidx_q;
                    grant_d = '0;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            gidx_q  <= '0;
            last_q  <= IW'(NUM_M - 1);
            grant_q <= '0;
            outst_q <= '0;
            wdog_q  <= '0;
            first_q <= 1'b0;
        end else begin
            state_q <= state_d;
            gidx_q  <= gidx_d;
            last_q  <= last_d;
            grant_q <= grant_d;
            outst_q <= outst_d;
            wdog_q  <= wdog_d;
            first_q <= first_d;
        end
    end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Directed bench for wb_rr_arbiter: two masters, MAX_OUTST=4, TIMEOUT=8.
module tb_wb_rr_arbiter;
    localparam int NUM_M     = 2;
    localparam int AW        = 32;
    localparam int DW        = 32;
    localparam int MAX_OUTST = 4;
    localparam int TIMEOUT   = 8;

    logic                  clk_i = 1'b0;
    logic                  rst_i;
    logic [NUM_M*AW-1:0]   m_adr_i;
    logic [NUM_M*DW-1:0]   m_dat_i;
    logic [NUM_M*DW/8-1:0] m_sel_i;
    logic [NUM_M-1:0]      m_we_i;
    logic [NUM_M-1:0]      m_cyc_i;
    logic [NUM_M-1:0]      m_stb_i;
    logic [DW-1:0]         m_dat_o;
    logic [NUM_M-1:0]      m_ack_o;
    logic [NUM_M-1:0]      m_err_o;
    logic [NUM_M-1:0]      m_stall_o;
    logic [AW-1:0]         s_adr_o;
    logic [DW-1:0]         s_dat_o;
    logic [DW/8-1:0]       s_sel_o;
    logic                  s_we_o;
    logic                  s_cyc_o;
    logic                  s_stb_o;
    logic [DW-1:0]         s_dat_i;
    logic                  s_ack_i;
    logic                  s_err_i;
    logic                  s_stall_i;
    logic [NUM_M-1:0]      grant_o;

    int n_cmp = 0;
    int n_bad = 0;

    wb_rr_arbiter #(
        .NUM_M(NUM_M), .AW(AW), .DW(DW), .MAX_OUTST(MAX_OUTST), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_sel_i(m_sel_i), .m_we_i(m_we_i),
        .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i),
        .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_stall_o(m_stall_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o),
        .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_stall_i(s_stall_i),
        .grant_o(grant_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL tb_time_limit: got still running want finished");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        m_cyc_i   = '0;
        m_stb_i   = '0;
        s_ack_i   = 1'b0;
        s_err_i   = 1'b0;
        s_stall_i = 1'b0;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        idle_inputs();
        step();
        step();
        rst_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_i   = 1'b1;
        m_cyc_i = 2'b11;
        m_stb_i = 2'b11;
        step();
        step();
        #1;
        n_cmp++; if (s_cyc_o !== 1'b0) begin n_bad++; $display("FAIL reset_cyc: got %b want 0", s_cyc_o); end
        n_cmp++; if (s_stb_o !== 1'b0) begin n_bad++; $display("FAIL reset_stb: got %b want 0", s_stb_o); end
        n_cmp++; if (m_ack_o !== 2'b00) begin n_bad++; $display("FAIL reset_ack: got %b want 00", m_ack_o); end
        n_cmp++; if (m_err_o !== 2'b00) begin n_bad++; $display("FAIL reset_err: got %b want 00", m_err_o); end
        n_cmp++; if (m_stall_o !== 2'b11) begin n_bad++; $display("FAIL reset_stall: got %b want 11", m_stall_o); end
        n_cmp++; if (grant_o !== 2'b00) begin n_bad++; $display("FAIL reset_grant: got %b want 00", grant_o); end
        idle_inputs();
    endtask

    task automatic test_single();
        do_reset();
        m_cyc_i[0] = 1'b1;
        m_stb_i[0] = 1'b1;
        #1;
        n_cmp++; if (s_cyc_o !== 1'b0) begin n_bad++; $display("FAIL single_req_cyc: got %b want 0", s_cyc_o); end
        n_cmp++; if (grant_o !== 2'b00) begin n_bad++; $display("FAIL single_req_grant: got %b want 00", grant_o); end
        step(); #1;
        n_cmp++; if (s_cyc_o !== 1'b1) begin n_bad++; $display("FAIL single_cyc: got %b want 1", s_cyc_o); end
        n_cmp++; if (s_stb_o !== 1'b1) begin n_bad++; $display("FAIL single_stb: got %b want 1", s_stb_o); end
        n_cmp++; if (s_adr_o !== 32'h100) begin n_bad++; $display("FAIL single_adr: got %h want 00000100", s_adr_o); end
        n_cmp++; if (s_we_o !== 1'b1) begin n_bad++; $display("FAIL single_we: got %b want 1", s_we_o); end
        n_cmp++; if (s_dat_o !== 32'hD0D0_0000) begin n_bad++; $display("FAIL single_wdat: got %h want d0d00000", s_dat_o); end
        n_cmp++; if (grant_o !== 2'b01) begin n_bad++; $display("FAIL single_grant: got %b want 01", grant_o); end
        n_cmp++; if (m_stall_o !== 2'b10) begin n_bad++; $display("FAIL single_stall: got %b want 10", m_stall_o); end
        step();
        m_stb_i[0] = 1'b0;
        #1;
        n_cmp++; if (m_ack_o !== 2'b00) begin n_bad++; $display("FAIL single_early_ack: got %b want 00", m_ack_o); end
        step();
        s_ack_i = 1'b1;
        s_dat_i = 32'hCAFE_0001;
        #1;
        n_cmp++; if (m_ack_o !== 2'b01) begin n_bad++; $display("FAIL single_ack: got %b want 01", m_ack_o); end
        n_cmp++; if (m_dat_o !== 32'hCAFE_0001) begin n_bad++; $display("FAIL single_rdat: got %h want cafe0001", m_dat_o); end
        step();
        s_ack_i    = 1'b0;
        m_cyc_i[0] = 1'b0;
        #1;
        n_cmp++; if (s_cyc_o !== 1'b0) begin n_bad++; $display("FAIL single_release_cyc: got %b want 0", s_cyc_o); end
        step(); #1;
        n_cmp++; if (grant_o !== 2'b00) begin n_bad++; $display("FAIL single_idle_grant: got %b want 00", grant_o); end
        n_cmp++; if (m_stall_o !== 2'b11) begin n_bad++; $display("FAIL single_idle_stall: got %b want 11", m_stall_o); end
        idle_inputs();
    endtask

    task automatic test_round_robin();
        logic [1:0]  exp_g;
        logic [31:0] exp_adr;
        do_reset();
        m_cyc_i = 2'b11;
        m_stb_i = 2'b11;
        for (int k = 0; k < 4; k++) begin
            exp_g   = (k % 2 == 0) ? 2'b01 : 2'b10;
            exp_adr = (k % 2 == 0) ? 32'h100 : 32'h200;
            #1;
            n_cmp++; if (grant_o !== 2'b00) begin n_bad++; $display("FAIL rr_gap_%0d: got %b want 00", k, grant_o); end
            step(); #1;
            n_cmp++; if (grant_o !== exp_g) begin n_bad++; $display("FAIL rr_grant_%0d: got %b want %b", k, grant_o, exp_g); end
            n_cmp++; if (s_adr_o !== exp_adr) begin n_bad++; $display("FAIL rr_adr_%0d: got %h want %h", k, s_adr_o, exp_adr); end
            n_cmp++; if (s_stb_o !== 1'b1) begin n_bad++; $display("FAIL rr_stb_%0d: got %b want 1", k, s_stb_o); end
            step();
            m_cyc_i = m_cyc_i & ~exp_g;
            m_stb_i = m_stb_i & ~exp_g;
            s_ack_i = 1'b1;
            #1;
            n_cmp++; if (m_ack_o !== exp_g) begin n_bad++; $display("FAIL rr_ack_%0d: got %b want %b", k, m_ack_o, exp_g); end
            n_cmp++; if (s_cyc_o !== 1'b0) begin n_bad++; $display("FAIL rr_release_%0d: got %b want 0", k, s_cyc_o); end
            step();
            s_ack_i = 1'b0;
            m_cyc_i = 2'b11;
            m_stb_i = 2'b11;
        end
        idle_inputs();
        step();
    endtask

    task automatic test_back_to_back();
        int model_outst = 0;
        int mcount      = 0;
        int acks        = 0;
        int stalls      = 0;
        int due[$];
        logic exp_stb;
        logic exp_ack;
        do_reset();
        m_cyc_i[1] = 1'b1;
        m_stb_i[1] = 1'b1;
        step();
        for (int b = 1; b <= 14; b++) begin
            m_stb_i[1] = (mcount < 6);
            s_ack_i    = (due.size() > 0 && due[0] == b);
            #1;
            exp_stb = m_stb_i[1] && (model_outst < MAX_OUTST);
            exp_ack = s_ack_i && (model_outst > 0);
            n_cmp++; if (s_stb_o !== exp_stb) begin n_bad++; $display("FAIL b2b_stb_%0d: got %b want %b", b, s_stb_o, exp_stb); end
            n_cmp++; if (m_ack_o !== {exp_ack, 1'b0}) begin n_bad++; $display("FAIL b2b_ack_%0d: got %b want %b0", b, m_ack_o, exp_ack); end
            n_cmp++; if (m_stall_o !== {model_outst == MAX_OUTST, 1'b1}) begin n_bad++; $display("FAIL b2b_stall_%0d: got %b want %b1", b, m_stall_o, model_outst == MAX_OUTST); end
            n_cmp++; if (grant_o !== 2'b10) begin n_bad++; $display("FAIL b2b_grant_%0d: got %b want 10", b, grant_o); end
            if (m_stall_o[1]) stalls++;
            if (m_ack_o[1]) acks++;
            if (exp_ack) begin
                void'(due.pop_front());
                model_outst--;
            end
            if (exp_stb) begin
                due.push_back(b + 5);
                model_outst++;
                mcount++;
            end
            step();
        end
        m_cyc_i = '0;
        m_stb_i = '0;
        s_ack_i = 1'b0;
        #1;
        n_cmp++; if (s_cyc_o !== 1'b0) begin n_bad++; $display("FAIL b2b_release: got %b want 0", s_cyc_o); end
        n_cmp++; if (acks !== 6) begin n_bad++; $display("FAIL b2b_ack_total: got %0d want 6", acks); end
        n_cmp++; if (stalls !== 2) begin n_bad++; $display("FAIL b2b_stall_cycles: got %0d want 2", stalls); end
        step();
        idle_inputs();
    endtask

    task automatic test_same_cycle();
        do_reset();
        m_cyc_i[0] = 1'b1;
        m_stb_i[0] = 1'b1;
        step(); #1;
        n_cmp++; if (s_stb_o !== 1'b1) begin n_bad++; $display("FAIL same_first_stb: got %b want 1", s_stb_o); end
        step(); #1;
        step();
        s_ack_i = 1'b1;
        #1;
        n_cmp++; if (m_ack_o !== 2'b01) begin n_bad++; $display("FAIL same_ack: got %b want 01", m_ack_o); end
        n_cmp++; if (s_stb_o !== 1'b1) begin n_bad++; $display("FAIL same_stb: got %b want 1", s_stb_o); end
        step();
        s_ack_i   = 1'b0;
        s_stall_i = 1'b1;
        #1;
        n_cmp++; if (s_stb_o !== 1'b1) begin n_bad++; $display("FAIL stall_stb_held: got %b want 1", s_stb_o); end
        n_cmp++; if (m_stall_o !== 2'b11) begin n_bad++; $display("FAIL stall_fwd: got %b want 11", m_stall_o); end
        step();
        s_stall_i = 1'b0;
        #1;
        n_cmp++; if (m_stall_o !== 2'b10) begin n_bad++; $display("FAIL same_outst3_stall: got %b want 10", m_stall_o); end
        step(); #1;
        n_cmp++; if (m_stall_o !== 2'b10) begin n_bad++; $display("FAIL same_outst4_issue_stall: got %b want 10", m_stall_o); end
        step(); #1;
        n_cmp++; if (m_stall_o !== 2'b11) begin n_bad++; $display("FAIL same_full_stall: got %b want 11", m_stall_o); end
        n_cmp++; if (s_stb_o !== 1'b0) begin n_bad++; $display("FAIL same_full_stb: got %b want 0", s_stb_o); end
        step();
        m_cyc_i = '0;
        m_stb_i = '0;
        #1;
        n_cmp++; if (s_cyc_o !== 1'b0) begin n_bad++; $display("FAIL same_release: got %b want 0", s_cyc_o); end
        step();
        idle_inputs();
    endtask

    task automatic test_timeout();
        do_reset();
        m_cyc_i    = 2'b11;
        m_stb_i[0] = 1'b1;
        step(); #1;
        n_cmp++; if (grant_o !== 2'b01) begin n_bad++; $display("FAIL to_grant0: got %b want 01", grant_o); end
        n_cmp++; if (s_stb_o !== 1'b1) begin n_bad++; $display("FAIL to_issue: got %b want 1", s_stb_o); end
        step();
        m_stb_i[0] = 1'b0;
        #1;
        for (int b = 2; b <= 9; b++) begin
            n_cmp++; if (s_cyc_o !== 1'b1) begin n_bad++; $display("FAIL to_wait_cyc_%0d: got %b want 1", b, s_cyc_o); end
            n_cmp++; if (m_err_o !== 2'b00) begin n_bad++; $display("FAIL to_wait_err_%0d: got %b want 00", b, m_err_o); end
            step(); #1;
        end
        n_cmp++; if (s_cyc_o !== 1'b0) begin n_bad++; $display("FAIL to_abort_cyc: got %b want 0", s_cyc_o); end
        n_cmp++; if (s_stb_o !== 1'b0) begin n_bad++; $display("FAIL to_abort_stb: got %b want 0", s_stb_o); end
        n_cmp++; if (m_err_o !== 2'b01) begin n_bad++; $display("FAIL to_abort_err: got %b want 01", m_err_o); end
        step();
        s_ack_i = 1'b1;
        #1;
        n_cmp++; if (m_err_o !== 2'b00) begin n_bad++; $display("FAIL to_err_once: got %b want 00", m_err_o); end
        n_cmp++; if (m_ack_o !== 2'b00) begin n_bad++; $display("FAIL to_abort_ack_ignored: got %b want 00", m_ack_o); end
        step();
        s_ack_i    = 1'b0;
        m_cyc_i[0] = 1'b0;
        #1;
        n_cmp++; if (s_cyc_o !== 1'b0) begin n_bad++; $display("FAIL to_drop_cyc: got %b want 0", s_cyc_o); end
        step(); #1;
        n_cmp++; if (grant_o !== 2'b00) begin n_bad++; $display("FAIL to_idle_grant: got %b want 00", grant_o); end
        step(); #1;
        n_cmp++; if (grant_o !== 2'b10) begin n_bad++; $display("FAIL to_next_grant: got %b want 10", grant_o); end
        idle_inputs();
        step();
    endtask

    task automatic test_spurious_reset();
        do_reset();
        m_cyc_i[1] = 1'b1;
        step();
        s_ack_i = 1'b1;
        s_err_i = 1'b1;
        #1;
        n_cmp++; if (grant_o !== 2'b10) begin n_bad++; $display("FAIL spur_grant: got %b want 10", grant_o); end
        n_cmp++; if (m_ack_o !== 2'b00) begin n_bad++; $display("FAIL spur_ack: got %b want 00", m_ack_o); end
        n_cmp++; if (m_err_o !== 2'b00) begin n_bad++; $display("FAIL spur_err: got %b want 00", m_err_o); end
        step();
        s_ack_i    = 1'b0;
        s_err_i    = 1'b0;
        m_stb_i[1] = 1'b1;
        #1;
        step();
        rst_i = 1'b1;
        #1;
        n_cmp++; if (s_stb_o !== 1'b1) begin n_bad++; $display("FAIL rst_mid_stb: got %b want 1", s_stb_o); end
        step();
        s_ack_i = 1'b1;
        #1;
        n_cmp++; if (s_cyc_o !== 1'b0) begin n_bad++; $display("FAIL rst_cyc: got %b want 0", s_cyc_o); end
        n_cmp++; if (s_stb_o !== 1'b0) begin n_bad++; $display("FAIL rst_stb: got %b want 0", s_stb_o); end
        n_cmp++; if (m_ack_o !== 2'b00) begin n_bad++; $display("FAIL rst_ack: got %b want 00", m_ack_o); end
        n_cmp++; if (m_stall_o !== 2'b11) begin n_bad++; $display("FAIL rst_stall: got %b want 11", m_stall_o); end
        n_cmp++; if (grant_o !== 2'b00) begin n_bad++; $display("FAIL rst_grant: got %b want 00", grant_o); end
        rst_i = 1'b0;
        step();
        #1;
        n_cmp++; if (grant_o !== 2'b10) begin n_bad++; $display("FAIL rst_regrant: got %b want 10", grant_o); end
        n_cmp++; if (m_ack_o !== 2'b00) begin n_bad++; $display("FAIL rst_outst_cleared: got %b want 00", m_ack_o); end
        idle_inputs();
        step();
    endtask

    initial begin
        rst_i     = 1'b1;
        m_adr_i   = {32'h0000_0200, 32'h0000_0100};
        m_dat_i   = {32'hD1D1_1111, 32'hD0D0_0000};
        m_sel_i   = '1;
        m_we_i    = 2'b01;
        s_dat_i   = '0;
        idle_inputs();

        test_reset();
        test_single();
        test_round_robin();
        test_back_to_back();
        test_same_cycle();
        test_timeout();
        test_spurious_reset();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
